md_sched: RTL and testbench

Multiply/divide scheduler for the five-stage pipeline.
- Owns the HI/LO registers and sequences multi-cycle `mult`/`multu`/`div`/`divu` operations issued from the E stage.
- Drives the stall request that holds any multiply/divide-class instruction in D while an operation is in flight.
- Sits beside the ALU in E; its stall output is ORed into `cw_f_pc_enable`/`cw_d_pff_enable` gating by the control unit.

---
 rtl/md_sched_pkg.sv | 40 ++++
 rtl/md_sched_if.sv | 28 ++
 rtl/md_arith.sv | 65 ++++++
 rtl/md_sched.sv | 108 ++++++++++
 tb/tb_md_sched.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_sched_pkg.sv
// Shared types for the multiply/divide scheduler: opcode and state encodings,
// the {hi, lo} result pair and small opcode classification helpers.
package md_sched_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } md_pair_t;

    // Ops that occupy the unit for several cycles.
    function automatic logic is_arith(md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// E/D-stage bundle between the pipeline (master) and the MD scheduler (slave).
// master drives e_valid, e_md_op, e_rs_val, e_rt_val, d_md_use;
// slave drives cw_md_busy, cw_md_stall, e_md_result, hi, lo.
interface md_sched_if;
    import md_sched_pkg::*;

    logic            e_valid;
    md_op_e          e_md_op;
    logic [XLEN-1:0] e_rs_val;
    logic [XLEN-1:0] e_rt_val;
    logic            d_md_use;
    logic            cw_md_busy;
    logic            cw_md_stall;
    logic [XLEN-1:0] e_md_result;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output e_valid, e_md_op, e_rs_val, e_rt_val, d_md_use,
        input  cw_md_busy, cw_md_stall, e_md_result, hi, lo
    );

    modport slave (
        input  e_valid, e_md_op, e_rs_val, e_rt_val, d_md_use,
        output cw_md_busy, cw_md_stall, e_md_result, hi, lo
    );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
// Ports: op_i (MD opcode), rs_i/rt_i (operands), res_c ({hi, lo} result;
// zero for non-arithmetic ops). Division is done on magnitudes so the
// signed case never divides the most negative value directly.
module md_arith
    import md_sched_pkg::*;
(
    input  md_op_e          op_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    output md_pair_t        res_c
);

    logic            is_s;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] div_b;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [63:0]     prod_s;
    logic [63:0]     prod_u;

    assign is_s  = (op_i == MD_DIV);
    assign neg_a = is_s & rs_i[XLEN-1];
    assign neg_b = is_s & rt_i[XLEN-1];
    assign mag_a = neg_a ? (~rs_i + XLEN'(1)) : rs_i;
    assign mag_b = neg_b ? (~rt_i + XLEN'(1)) : rt_i;
    // Divisor forced non-zero so the divider never sees 0; that case is muxed out.
    assign div_b = (rt_i == '0) ? XLEN'(1) : mag_b;
    assign q_mag = mag_a / div_b;
    assign r_mag = mag_a % div_b;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign q_fix = (neg_a ^ neg_b) ? (~q_mag + XLEN'(1)) : q_mag;
    assign r_fix = neg_a ? (~r_mag + XLEN'(1)) : r_mag;

    assign prod_s = 64'($signed({{XLEN{rs_i[XLEN-1]}}, rs_i}) * $signed({{XLEN{rt_i[XLEN-1]}}, rt_i}));
    assign prod_u = 64'({32'd0, rs_i} * {32'd0, rt_i});

    // Result select with divide-by-zero and signed overflow rules.
    always_comb begin
        res_c = '0;
        unique case (op_i)
            MD_MULT:  res_c = md_pair_t'(prod_s);
            MD_MULTU: res_c = md_pair_t'(prod_u);
            MD_DIV, MD_DIVU: begin
                if (rt_i == '0) begin
                    res_c.hi = rs_i;
                    res_c.lo = 32'hFFFF_FFFF;
                end else if (is_s && rs_i == 32'h8000_0000 && rt_i == 32'hFFFF_FFFF) begin
                    res_c.hi = '0;
                    res_c.lo = 32'h8000_0000;
                end else begin
                    res_c.hi = r_fix;
                    res_c.lo = q_fix;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, sequences multi-cycle mult/div ops
// issued from E and requests an F/D freeze while an MD-class op waits in D.
// Ports: clk, rst_n (async active-low); md (slave modport of md_sched_if):
// E-stage op/operands in, busy/stall/MF result/architectural HI/LO out.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    md_sched_if.slave  md
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_pair_t         pend_q, pend_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    md_pair_t         arith_res;

    logic             busy_c;
    logic             start_c;
    logic             commit_c;
    logic [XLEN-1:0]  result_c;

    md_arith u_arith (
        .op_i  (md.e_md_op),
        .rs_i  (md.e_rs_val),
        .rt_i  (md.e_rt_val),
        .res_c (arith_res)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_c) state_d = is_div(md.e_md_op) ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (commit_c) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; any E-stage MD op while busy falls through untouched.
    always_comb begin
        busy_c   = (state_q != ST_IDLE);
        start_c  = !busy_c && md.e_valid && is_arith(md.e_md_op);
        commit_c = busy_c && (cnt_q == CNT_W'(1));
    end

    // Counter, pending result and HI/LO next values
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (start_c) begin
            cnt_d  = is_div(md.e_md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_d = arith_res;
        end else if (busy_c) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (commit_c) begin
                hi_d = pend_q.hi;
                lo_d = pend_q.lo;
            end
        end else if (md.e_valid && md.e_md_op == MD_MTHI) begin
            hi_d = md.e_rs_val;
        end else if (md.e_valid && md.e_md_op == MD_MTLO) begin
            lo_d = md.e_rs_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pend_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // MFHI/MFLO read the current architectural value.
    always_comb begin
        result_c = '0;
        if (md.e_md_op == MD_MFHI)      result_c = hi_q;
        else if (md.e_md_op == MD_MFLO) result_c = lo_q;
    end

    assign md.cw_md_busy  = busy_c;
    assign md.cw_md_stall = md.d_md_use && (busy_c || start_c);
    assign md.e_md_result = result_c;
    assign md.hi          = hi_q;
    assign md.lo          = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: the stimulus process pushes the expected
// per-cycle outputs from a behavioural model, a monitor pops and compares.
module tb_md_sched;
    import md_sched_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md_sched_if bus ();

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (bus)
    );

    typedef struct {
        logic        busy;
        logic        stall;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    // Model state: architectural HI/LO, cycles left in flight, pending result.
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_pend = '0;
    int          m_rem  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_arith(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt);
        longint      a, b, q, r, p;
        logic [63:0] pv, qv, rv;
        case (op)
            MD_MULT, MD_MULTU: begin
                a  = (op == MD_MULT) ? longint'($signed(rs)) : longint'({32'd0, rs});
                b  = (op == MD_MULT) ? longint'($signed(rt)) : longint'({32'd0, rt});
                p  = a * b;
                pv = p;
                return pv;
            end
            MD_DIV, MD_DIVU: begin
                if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
                a  = (op == MD_DIV) ? longint'($signed(rs)) : longint'({32'd0, rs});
                b  = (op == MD_DIV) ? longint'($signed(rt)) : longint'({32'd0, rt});
                q  = a / b;
                r  = a % b;
                qv = q;
                rv = r;
                return {rv[31:0], qv[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic arith_op(input md_op_e op);
        return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
    endfunction

    // One clock of stimulus: drive inputs, push expected outputs, advance model.
    task automatic step(input logic v, input md_op_e op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic du, input logic rst);
        exp_t e;
        logic busy, start;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            rst_n  = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            m_pend = '0;
            m_rem  = 0;
        end else begin
            rst_n = 1'b1;
        end
        bus.e_valid  = v;
        bus.e_md_op  = op;
        bus.e_rs_val = rs;
        bus.e_rt_val = rt;
        bus.d_md_use = du;
        busy    = (m_rem > 0);
        start   = !rst && !busy && v && arith_op(op);
        e.busy  = busy;
        e.stall = !rst && du && (busy || start);
        e.res   = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'd0;
        e.hi    = m_hi;
        e.lo    = m_lo;
        e.cyc   = cyc;
        sb.push_back(e);
        if (!rst) begin
            if (busy) begin
                m_rem--;
                if (m_rem == 0) {m_hi, m_lo} = m_pend;
            end else if (start) begin
                m_pend = ref_arith(op, rs, rt);
                m_rem  = (op == MD_DIV || op == MD_DIVU) ? int'(DC) : int'(MC);
            end else if (v && op == MD_MTHI) begin
                m_hi = rs;
            end else if (v && op == MD_MTLO) begin
                m_lo = rs;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic du);
        for (int i = 0; i < n; i++) step(1'b0, MD_NONE, 32'd0, 32'd0, du, 1'b0);
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk($sformatf("c%0d busy", mon_e.cyc),   32'(bus.cw_md_busy),  32'(mon_e.busy));
            chk($sformatf("c%0d stall", mon_e.cyc),  32'(bus.cw_md_stall), 32'(mon_e.stall));
            chk($sformatf("c%0d result", mon_e.cyc), bus.e_md_result,      mon_e.res);
            chk($sformatf("c%0d hi", mon_e.cyc),     bus.hi,               mon_e.hi);
            chk($sformatf("c%0d lo", mon_e.cyc),     bus.lo,               mon_e.lo);
        end
    end

    int n;

    initial begin
        bus.e_valid  = 1'b0;
        bus.e_md_op  = MD_NONE;
        bus.e_rs_val = '0;
        bus.e_rt_val = '0;
        bus.d_md_use = 1'b0;

        step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("reset busy", 32'(bus.cw_md_busy), 32'd0);
        chk("reset hi", bus.hi, 32'd0);

        // MULT -1 * 2
        step(1'b1, MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1, 1'b0);
            n += int'(bus.cw_md_busy);
        end
        chk("mult busy cycles", 32'(n), 32'd5);
        chk("mult hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult lo", bus.lo, 32'hFFFF_FFFE);

        // MULTU same operands
        step(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        idle(MC + 1, 1'b0);
        chk("multu hi", bus.hi, 32'd1);
        chk("multu lo", bus.lo, 32'hFFFF_FFFE);

        // DIV -7 / 2 with MFLO waiting in D
        step(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        n = int'(bus.cw_md_stall);
        for (int i = 0; i < 14 && bus.cw_md_stall; i++) begin
            idle(1, 1'b1);
            n += int'(bus.cw_md_stall);
        end
        chk("div stall cycles", 32'(n), 32'd11);
        step(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("div mflo", bus.e_md_result, 32'hFFFF_FFFD);
        chk("div hi", bus.hi, 32'hFFFF_FFFF);

        // DIVU by zero
        step(1'b1, MD_DIVU, 32'd42, 32'd0, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);
        chk("divu0 lo", bus.lo, 32'hFFFF_FFFF);
        chk("divu0 hi", bus.hi, 32'd42);

        // Signed overflow
        step(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);
        chk("ovf lo", bus.lo, 32'h8000_0000);
        chk("ovf hi", bus.hi, 32'd0);

        // Reset in busy cycle 4 of a DIV
        step(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("midrst busy", 32'(bus.cw_md_busy), 32'd0);
        chk("midrst lo", bus.lo, 32'd0);
        step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b1, MD_MTLO, 32'd5, 32'd0, 1'b0, 1'b0);
        step(1'b1, MD_NONE, 32'd1, 32'd2, 1'b0, 1'b0);
        chk("mtlo lo", bus.lo, 32'd5);
        chk("addu stall", 32'(bus.cw_md_stall), 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rs, rt;
            md_op_e      op;
            case ($urandom_range(0, 5))
                0:       rs = 32'h8000_0000;
                1:       rs = 32'd0;
                default: rs = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rt = 32'd0;
                1:       rt = 32'hFFFF_FFFF;
                2:       rt = 32'($urandom_range(0, 9));
                default: rt = $urandom;
            endcase
            op = md_op_e'(4'($urandom_range(0, 8)));
            step($urandom_range(0, 3) != 0, op, rs, rt, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 199) == 0);
        end

        idle(2, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
